// File: rtl/reg_file_if.sv
// Decoder/ROB-facing bundle for the architectural register file.
// The master drives issue, commit and flush and receives both operand lookups.
interface reg_file_if #(
    parameter int REG_NUM_WIDTH  = 5,
    parameter int ROB_SIZE_WIDTH = 5
);
    logic                      dec_valid;
    logic [REG_NUM_WIDTH-1:0]  dec_rd;
    logic [ROB_SIZE_WIDTH-1:0] dec_rob_id;
    logic [REG_NUM_WIDTH-1:0]  dec_rs1;
    logic [REG_NUM_WIDTH-1:0]  dec_rs2;

    logic                      rob_valid;
    logic [REG_NUM_WIDTH-1:0]  rob_rd;
    logic [31:0]               rob_value;
    logic [ROB_SIZE_WIDTH-1:0] rob_dependency;

    logic                      flush_in;

    logic                      busy1_out;
    logic                      busy2_out;
    logic [ROB_SIZE_WIDTH-1:0] dep1_out;
    logic [ROB_SIZE_WIDTH-1:0] dep2_out;
    logic [31:0]               value1_out;
    logic [31:0]               value2_out;

    modport master (
        output dec_valid, dec_rd, dec_rob_id, dec_rs1, dec_rs2,
        output rob_valid, rob_rd, rob_value, rob_dependency, flush_in,
        input  busy1_out, busy2_out, dep1_out, dep2_out, value1_out, value2_out
    );

    modport slave (
        input  dec_valid, dec_rd, dec_rob_id, dec_rs1, dec_rs2,
        input  rob_valid, rob_rd, rob_value, rob_dependency, flush_in,
        output busy1_out, busy2_out, dep1_out, dep2_out, value1_out, value2_out
    );
endinterface

// File: rtl/reg_file.sv
// Architectural register file with per-register rename tags: issue claims a
// destination, in-order commit writes back and releases matching claims.
module reg_file #(
    parameter int REG_NUM_WIDTH  = 5,
    parameter int ROB_SIZE_WIDTH = 5
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       rdy_in,
    reg_file_if.slave  rf
);
    localparam int NREG = 1 << REG_NUM_WIDTH;

    typedef struct packed {
        logic                      busy;
        logic [ROB_SIZE_WIDTH-1:0] dep;
        logic [31:0]               value;
    } lookup_t;

    logic [31:0]               value_q [NREG];
    logic [31:0]               value_d [NREG];
    logic [ROB_SIZE_WIDTH-1:0] tag_q   [NREG];
    logic [ROB_SIZE_WIDTH-1:0] tag_d   [NREG];
    logic [NREG-1:0]           busy_q;
    logic [NREG-1:0]           busy_d;

    logic    commit_en;
    logic    flush_en;
    logic    issue_en;
    lookup_t lk1;
    lookup_t lk2;

    // x0 is never written, so its storage stays at the reset value of zero.
    assign commit_en = rdy_in && rf.rob_valid && (rf.rob_rd != '0);
    assign flush_en  = rdy_in && rf.flush_in;
    assign issue_en  = rdy_in && rf.dec_valid && (rf.dec_rd != '0) && !rf.flush_in;

    always_comb begin
        value_d = value_q;
        tag_d   = tag_q;
        busy_d  = busy_q;
        if (commit_en) begin
            value_d[rf.rob_rd] = rf.rob_value;
            // A mismatched tag means a younger claim owns the register.
            if (tag_q[rf.rob_rd] == rf.rob_dependency) begin
                busy_d[rf.rob_rd] = 1'b0;
            end
        end
        if (flush_en) begin
            busy_d = '0;
        end else if (issue_en) begin
            busy_d[rf.dec_rd] = 1'b1;
            tag_d[rf.dec_rd]  = rf.dec_rob_id;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            for (int i = 0; i < NREG; i++) begin
                value_q[i] <= '0;
                tag_q[i]   <= '0;
            end
            busy_q <= '0;
        end else begin
            value_q <= value_d;
            tag_q   <= tag_d;
            busy_q  <= busy_d;
        end
    end

    // Lookups see registered state plus the same-cycle commit; a same-cycle
    // issue is deliberately invisible so an instruction reads its old rd.
    function automatic lookup_t lookup(input logic [REG_NUM_WIDTH-1:0] rs);
        lookup_t res;
        if (rs == '0) begin
            res = '0;
        end else if (commit_en && (rf.rob_rd == rs) && busy_q[rs] &&
                     (tag_q[rs] == rf.rob_dependency)) begin
            res.busy  = 1'b0;
            res.dep   = tag_q[rs];
            res.value = rf.rob_value;
        end else begin
            res.busy  = busy_q[rs];
            res.dep   = tag_q[rs];
            res.value = value_q[rs];
        end
        return res;
    endfunction

    always_comb begin
        lk1 = lookup(rf.dec_rs1);
        lk2 = lookup(rf.dec_rs2);
    end

    assign rf.busy1_out  = lk1.busy;
    assign rf.dep1_out   = lk1.dep;
    assign rf.value1_out = lk1.value;
    assign rf.busy2_out  = lk2.busy;
    assign rf.dep2_out   = lk2.dep;
    assign rf.value2_out = lk2.value;
endmodule

// File: tb/tb_reg_file.sv
// Randomized scoreboard bench for reg_file: a driver pushes expected lookups
// from a register-array model; a monitor pops and compares on the falling edge.
module tb_reg_file;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rdy = 1'b1;

    reg_file_if #(.REG_NUM_WIDTH(5), .ROB_SIZE_WIDTH(5)) bus ();

    reg_file #(.REG_NUM_WIDTH(5), .ROB_SIZE_WIDTH(5)) dut (
        .clk_in (clk),
        .rst_in (rst_n),
        .rdy_in (rdy),
        .rf     (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        b1;
        logic [4:0]  d1;
        logic        dc1;
        logic [31:0] v1;
        logic        b2;
        logic [4:0]  d2;
        logic        dc2;
        logic [31:0] v2;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;
    bit done = 0;

    logic [31:0] m_val [32];
    logic [4:0]  m_tag [32];
    bit          m_busy[32];

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_look(input logic [4:0] rs, output logic b, output logic [4:0] d,
                          output logic dc, output logic [31:0] v);
        b = 0; d = 0; dc = 1; v = 0;
        if (rs != 0) begin
            if (rdy && bus.rob_valid && bus.rob_rd == rs && m_busy[rs] &&
                m_tag[rs] == bus.rob_dependency) begin
                v = bus.rob_value;
                dc = 0;
            end else begin
                b = m_busy[rs];
                d = m_tag[rs];
                v = m_val[rs];
            end
        end
    endtask

    task automatic m_update();
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                m_val[i] = 0; m_tag[i] = 0; m_busy[i] = 0;
            end
        end else if (rdy) begin
            if (bus.rob_valid && bus.rob_rd != 0) begin
                m_val[bus.rob_rd] = bus.rob_value;
                if (m_tag[bus.rob_rd] == bus.rob_dependency) m_busy[bus.rob_rd] = 0;
            end
            if (bus.flush_in) begin
                for (int i = 0; i < 32; i++) m_busy[i] = 0;
            end else if (bus.dec_valid && bus.dec_rd != 0) begin
                m_busy[bus.dec_rd] = 1;
                m_tag[bus.dec_rd] = bus.dec_rob_id;
            end
        end
    endtask

    task automatic idle();
        rst_n = 1; rdy = 1;
        bus.dec_valid = 0; bus.dec_rd = 0; bus.dec_rob_id = 0;
        bus.dec_rs1 = 0; bus.dec_rs2 = 0;
        bus.rob_valid = 0; bus.rob_rd = 0; bus.rob_value = 0; bus.rob_dependency = 0;
        bus.flush_in = 0;
    endtask

    // Called just after a rising edge with inputs set; the bypass of a
    // stalled commit is left unchecked, as are reset cycles.
    task automatic step(input bit known);
        exp_t e;
        if (known && rst_n && !(!rdy && bus.rob_valid)) begin
            m_look(bus.dec_rs1, e.b1, e.d1, e.dc1, e.v1);
            m_look(bus.dec_rs2, e.b2, e.d2, e.dc2, e.v2);
            q.push_back(e);
        end
        m_update();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] rnd_reg();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 7));
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                cmp("busy1", 32'(bus.busy1_out), 32'(e.b1));
                if (e.dc1) cmp("dep1", 32'(bus.dep1_out), 32'(e.d1));
                cmp("value1", bus.value1_out, e.v1);
                cmp("busy2", 32'(bus.busy2_out), 32'(e.b2));
                if (e.dc2) cmp("dep2", 32'(bus.dep2_out), 32'(e.d2));
                cmp("value2", bus.value2_out, e.v2);
            end
        end
    end

    initial begin : driver
        logic [4:0] r;
        idle();
        rst_n = 0;
        @(posedge clk);
        #1;
        // Reset, then lookups and an ignored x0 claim.
        idle(); rst_n = 0; step(0);
        idle(); bus.dec_rs1 = 5; bus.dec_rs2 = 31; step(1);
        idle(); bus.dec_valid = 1; bus.dec_rd = 0; bus.dec_rob_id = 3; step(1);
        idle(); bus.dec_rs1 = 0; step(1);
        // Rename then commit with zero-cycle bypass.
        idle(); bus.dec_valid = 1; bus.dec_rd = 4; bus.dec_rob_id = 7; step(1);
        idle(); bus.dec_rs1 = 4; step(1);
        idle(); bus.dec_rs1 = 4; bus.rob_valid = 1; bus.rob_rd = 4;
        bus.rob_value = 32'hDEADBEEF; bus.rob_dependency = 7; step(1);
        idle(); bus.dec_rs1 = 4; step(1);
        // Stale commit leaves the younger claim.
        idle(); bus.dec_valid = 1; bus.dec_rd = 6; bus.dec_rob_id = 2; step(1);
        idle(); bus.dec_valid = 1; bus.dec_rd = 6; bus.dec_rob_id = 9; step(1);
        idle(); bus.dec_rs1 = 6; bus.rob_valid = 1; bus.rob_rd = 6;
        bus.rob_value = 32'h11; bus.rob_dependency = 2; step(1);
        idle(); bus.dec_rs1 = 6; step(1);
        // Issue/commit collision on the same register.
        idle(); bus.dec_valid = 1; bus.dec_rd = 8; bus.dec_rob_id = 1; step(1);
        idle(); bus.dec_rs1 = 8; bus.rob_valid = 1; bus.rob_rd = 8; bus.rob_value = 32'h55;
        bus.rob_dependency = 1; bus.dec_valid = 1; bus.dec_rd = 8; bus.dec_rob_id = 4; step(1);
        idle(); bus.dec_rs1 = 8; step(1);
        // Flush with same-cycle commit and dropped issue.
        idle(); bus.dec_valid = 1; bus.dec_rd = 1; bus.dec_rob_id = 10; step(1);
        idle(); bus.dec_valid = 1; bus.dec_rd = 2; bus.dec_rob_id = 11; step(1);
        idle(); bus.dec_valid = 1; bus.dec_rd = 3; bus.dec_rob_id = 12; step(1);
        idle(); bus.flush_in = 1; bus.rob_valid = 1; bus.rob_rd = 1; bus.rob_value = 32'h40;
        bus.rob_dependency = 10; bus.dec_valid = 1; bus.dec_rd = 2; bus.dec_rob_id = 5; step(1);
        idle(); bus.dec_rs1 = 1; bus.dec_rs2 = 2; step(1);
        idle(); bus.dec_rs1 = 3; bus.dec_rs2 = 8; step(1);
        // Global enable low holds all state.
        idle(); bus.rob_valid = 1; bus.rob_rd = 3; bus.rob_value = 32'h33; bus.rob_dependency = 12; step(1);
        idle(); rdy = 0; bus.dec_valid = 1; bus.dec_rd = 3; bus.dec_rob_id = 6;
        bus.rob_valid = 1; bus.rob_rd = 3; bus.rob_value = 32'h77; bus.rob_dependency = 12; step(1);
        idle(); bus.dec_rs1 = 3; step(1);
        // Randomized traffic with occasional flush, stall and reset.
        for (int n = 0; n < 3000; n++) begin
            idle();
            rst_n = ($urandom_range(0, 299) != 0);
            rdy = ($urandom_range(0, 7) != 0);
            bus.dec_rs1 = rnd_reg();
            bus.dec_rs2 = rnd_reg();
            bus.dec_valid = ($urandom_range(0, 1) == 1);
            bus.dec_rd = rnd_reg();
            bus.dec_rob_id = 5'($urandom_range(0, 31));
            bus.rob_valid = ($urandom_range(0, 1) == 1);
            r = ($urandom_range(0, 2) == 0) ? bus.dec_rs1 : rnd_reg();
            bus.rob_rd = r;
            bus.rob_value = $urandom;
            bus.rob_dependency = ($urandom_range(0, 3) != 0) ? m_tag[r] : 5'($urandom_range(0, 31));
            bus.flush_in = ($urandom_range(0, 31) == 0);
            step(1);
        end
        idle();
        for (int k = 0; k < 10 && q.size() != 0; k++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d expected=0 pending entries", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
